// File: rtl/gb_cpu_pkg.sv
// Shared definitions for the CPU stack datapath.
//   - Register-pair encodings (BC/DE/HL/AF) as seen on the pair select bus.
//   - Stack sequencer state encoding.
//   - Stack pointer reset default and the F-register low-nibble mask.
//   - Helper that applies the F-register masking to pair write data.
package gb_cpu_pkg;

  localparam logic [1:0] PAIR_BC = 2'b00;
  localparam logic [1:0] PAIR_DE = 2'b01;
  localparam logic [1:0] PAIR_HL = 2'b10;
  localparam logic [1:0] PAIR_AF = 2'b11;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PUSH_H = 3'd1,
    ST_PUSH_L = 3'd2,
    ST_POP_L  = 3'd3,
    ST_POP_H  = 3'd4,
    ST_WB     = 3'd5,
    ST_DONE   = 3'd6
  } seq_state_e;

  localparam logic [15:0] SP_RESET_DEFAULT = 16'hFFFE;

  // The low nibble of F is hardwired to zero in the CPU, so a popped AF
  // must never write ones into it.
  localparam logic [15:0] F_LOW_MASK = 16'hFFF0;

  function automatic logic [15:0] mask_pair_wdata(input logic [1:0]  pair,
                                                  input logic [15:0] data);
    return (pair == PAIR_AF) ? (data & F_LOW_MASK) : data;
  endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Byte-wide memory bus used by the stack sequencer.
//   mem_req   : transfer request, held until mem_ack is sampled high
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : 16-bit byte address
//   mem_wdata : write byte
//   mem_rdata : read byte (valid in the cycle mem_ack is high)
//   mem_ack   : transfer completes on the rising edge where it is high
// master = sequencer side, slave = memory side.
interface stack_sequencer_if;

  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/stack_sequencer_stack_ptr.sv
// stack_ptr: 16-bit stack pointer register.
//   clk, rst_n   : clock, asynchronous active-low reset (loads SP_RESET)
//   load_i       : load load_val_i (highest priority)
//   load_val_i   : value to load
//   inc_i, dec_i : +1 / -1, wrapping modulo 2^16
//   sp_o         : current stack pointer
module stack_ptr
  import gb_cpu_pkg::*;
#(
  parameter logic [15:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        inc_i,
  input  logic        dec_i,
  output logic [15:0] sp_o
);

  logic [15:0] sp_q, sp_d;

  always_comb begin
    sp_d = sp_q;
    if (load_i)     sp_d = load_val_i;
    else if (inc_i) sp_d = sp_q + 16'd1;
    else if (dec_i) sp_d = sp_q - 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= SP_RESET;
    else        sp_q <= sp_d;
  end

  assign sp_o = sp_q;

endmodule

// File: rtl/stack_sequencer.sv
// stack_sequencer: runs one PUSH or POP of a 16-bit register pair through
// a byte-wide memory bus, high byte at the higher address.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, op, pair : request (op 0=PUSH 1=POP; pair 00=BC 01=DE 10=HL 11=AF)
//   ready, done     : idle-and-free indicator, one-cycle completion pulse
//   rf_pair_*       : register-file pair select / readback / write
//   mem             : stack_sequencer_if master (memory bus)
//   sp_load(_val)   : load SP while idle; sp_out : current SP
// Optional feature macro PC_STACK_EN adds pc_sel/pc_in/pc_out/pc_we so the
// program counter can be pushed/popped instead of a register pair.
module stack_sequencer
  import gb_cpu_pkg::*;
#(
  parameter logic [15:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [1:0]  pair,
  output logic        ready,
  output logic        done,
  output logic [1:0]  rf_pair_sel,
  input  logic [15:0] rf_pair_rdata,
  output logic [15:0] rf_pair_wdata,
  output logic        rf_pair_we,
  stack_sequencer_if.master mem,
  input  logic        sp_load,
  input  logic [15:0] sp_load_val,
  output logic [15:0] sp_out
`ifdef PC_STACK_EN
  ,
  input  logic        pc_sel,
  input  logic [15:0] pc_in,
  output logic [15:0] pc_out,
  output logic        pc_we
`endif
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] PUSH_H = ST_PUSH_H;
  localparam logic [2:0] PUSH_L = ST_PUSH_L;
  localparam logic [2:0] POP_L  = ST_POP_L;
  localparam logic [2:0] POP_H  = ST_POP_H;
  localparam logic [2:0] WB     = ST_WB;
  localparam logic [2:0] DONE   = ST_DONE;

  logic [2:0]  state_q, state_d;
  logic        op_q, op_d;
  logic [1:0]  pair_q, pair_d;
  logic [15:0] data_q, data_d;
  logic [15:0] push_src;
  logic        is_idle, accept, xfer_done, to_pc;
  logic [15:0] sp;

  assign is_idle = (state_q == IDLE);
  // sp_load wins over a simultaneous start; the start is simply dropped.
  assign accept    = is_idle && start && !sp_load;
  assign xfer_done = mem.mem_req && mem.mem_ack;

`ifdef PC_STACK_EN
  logic pc_sel_q, pc_sel_d;
  assign push_src = pc_sel ? pc_in : rf_pair_rdata;
  assign to_pc    = pc_sel_q;
`else
  assign push_src = rf_pair_rdata;
  assign to_pc    = 1'b0;
`endif

  stack_ptr #(.SP_RESET(SP_RESET)) u_stack_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (is_idle && sp_load),
    .load_val_i (sp_load_val),
    .inc_i      (xfer_done && (op_q == OP_POP)),
    .dec_i      (xfer_done && (op_q == OP_PUSH)),
    .sp_o       (sp)
  );

  assign sp_out = sp;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pair_d  = pair_q;
    data_d  = data_q;
`ifdef PC_STACK_EN
    pc_sel_d = pc_sel_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = op;
          pair_d = pair;
`ifdef PC_STACK_EN
          pc_sel_d = pc_sel;
`endif
          if (op == OP_PUSH) begin
            data_d  = push_src;
            state_d = PUSH_H;
          end else begin
            state_d = POP_L;
          end
        end
      end
      PUSH_H: if (mem.mem_ack) state_d = PUSH_L;
      PUSH_L: if (mem.mem_ack) state_d = DONE;
      POP_L: begin
        if (mem.mem_ack) begin
          data_d[7:0] = mem.mem_rdata;
          state_d     = POP_H;
        end
      end
      POP_H: begin
        if (mem.mem_ack) begin
          data_d[15:8] = mem.mem_rdata;
          state_d      = WB;
        end
      end
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_PUSH;
      pair_q  <= PAIR_BC;
      data_q  <= '0;
`ifdef PC_STACK_EN
      pc_sel_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pair_q  <= pair_d;
      data_q  <= data_d;
`ifdef PC_STACK_EN
      pc_sel_q <= pc_sel_d;
`endif
    end
  end

  // Bus outputs decode only from registered state and SP, which cannot
  // change until the ack edge, so they stay stable while a transfer waits.
  // Pushes pre-decrement (write at SP-1), pops post-increment (read at SP).
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state_q)
      PUSH_H: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = sp - 16'd1;
        mem.mem_wdata = data_q[15:8];
      end
      PUSH_L: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = sp - 16'd1;
        mem.mem_wdata = data_q[7:0];
      end
      POP_L, POP_H: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = sp;
      end
      default: ;
    endcase
  end

  assign rf_pair_sel   = is_idle ? pair : pair_q;
  assign rf_pair_we    = (state_q == WB) && !to_pc;
  assign rf_pair_wdata = rf_pair_we ? mask_pair_wdata(pair_q, data_q) : 16'h0000;
  assign done          = (state_q == DONE);
  assign ready         = is_idle && !sp_load;

`ifdef PC_STACK_EN
  // PC has no flag nibble, so it is written back unmasked.
  assign pc_we  = (state_q == WB) && to_pc;
  assign pc_out = pc_we ? data_q : 16'h0000;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: byte memory with programmable ack
// delay, register-file readback table and write log.
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, op, sp_load;
  logic [1:0]  pair;
  logic        ready, done, rf_pair_we;
  logic [1:0]  rf_pair_sel;
  logic [15:0] rf_pair_rdata, rf_pair_wdata, sp_load_val, sp_out;

  stack_sequencer_if bus ();

  stack_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .op            (op),
    .pair          (pair),
    .ready         (ready),
    .done          (done),
    .rf_pair_sel   (rf_pair_sel),
    .rf_pair_rdata (rf_pair_rdata),
    .rf_pair_wdata (rf_pair_wdata),
    .rf_pair_we    (rf_pair_we),
    .mem           (bus.master),
    .sp_load       (sp_load),
    .sp_load_val   (sp_load_val),
    .sp_out        (sp_out)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [7:0]  mem [0:65535];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [15:0] wr_addr [0:31];
  logic [7:0]  wr_data [0:31];
  int          wr_cnt = 0;

  assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);
  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (bus.mem_req) begin
      if (bus.mem_ack) begin
        wait_cnt <= 0;
        if (bus.mem_we) begin
          mem[bus.mem_addr] <= bus.mem_wdata;
          wr_addr[wr_cnt[4:0]] <= bus.mem_addr;
          wr_data[wr_cnt[4:0]] <= bus.mem_wdata;
          wr_cnt <= wr_cnt + 1;
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Register-file model
  logic [15:0] rf_val [0:3];
  int          wb_cnt = 0;
  logic [15:0] wb_last = '0;
  logic [1:0]  wb_sel = '0;

  assign rf_pair_rdata = rf_val[rf_pair_sel];

  always @(posedge clk) begin
    if (rf_pair_we) begin
      wb_cnt  <= wb_cnt + 1;
      wb_last <= rf_pair_wdata;
      wb_sel  <= rf_pair_sel;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Issues one operation, returns the number of negedges after the
  // acceptance edge at which done is first seen (0 = never).
  task automatic run_op(input logic o, input logic [1:0] p, output int lat);
    lat = 0;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    pair  = p;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("ready_after_op", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    int wb0;
    rst_n = 1'b0;
    start = 1'b0;
    op = 1'b0;
    pair = 2'b00;
    sp_load = 1'b0;
    sp_load_val = '0;
    rf_val[0] = 16'h1234;
    rf_val[1] = 16'h0000;
    rf_val[2] = 16'h0000;
    rf_val[3] = 16'h0000;

    // Reset state
    #12;
    check("rst_sp", {16'd0, sp_out}, 32'h0000FFFE);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    check("rst_rf_we", {31'd0, rf_pair_we}, 32'd0);
    check("rst_rf_wdata", {16'd0, rf_pair_wdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pair select follows the pair input while idle
    @(negedge clk);
    pair = 2'b10;
    #1 check("idle_pair_sel", {30'd0, rf_pair_sel}, 32'd2);

    // PUSH BC = 1234
    base = wr_cnt;
    run_op(1'b0, 2'b00, lat);
    check("push_bc_lat", lat, 3);
    check("push_bc_wr_cnt", wr_cnt - base, 2);
    check("push_bc_a0", {16'd0, wr_addr[base]}, 32'h0000FFFD);
    check("push_bc_d0", {24'd0, wr_data[base]}, 32'h12);
    check("push_bc_a1", {16'd0, wr_addr[base+1]}, 32'h0000FFFC);
    check("push_bc_d1", {24'd0, wr_data[base+1]}, 32'h34);
    check("push_bc_sp", {16'd0, sp_out}, 32'h0000FFFC);

    // POP AF with FFFC=FF, FFFD=A5
    poke(16'hFFFC, 8'hFF);
    poke(16'hFFFD, 8'hA5);
    wb0 = wb_cnt;
    run_op(1'b1, 2'b11, lat);
    check("pop_af_lat", lat, 4);
    check("pop_af_wb_cnt", wb_cnt - wb0, 1);
    check("pop_af_wdata", {16'd0, wb_last}, 32'h0000A5F0);
    check("pop_af_sel", {30'd0, wb_sel}, 32'd3);
    check("pop_af_sp", {16'd0, sp_out}, 32'h0000FFFE);

    // sp_load 0001, then PUSH HL = BEEF wraps through 0000
    @(negedge clk);
    sp_load = 1'b1;
    sp_load_val = 16'h0001;
    #1 check("ready_during_load", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1 sp_load = 1'b0;
    check("sp_loaded", {16'd0, sp_out}, 32'h00000001);
    rf_val[2] = 16'hBEEF;
    base = wr_cnt;
    run_op(1'b0, 2'b10, lat);
    check("push_hl_lat", lat, 3);
    check("push_hl_a0", {16'd0, wr_addr[base]}, 32'h00000000);
    check("push_hl_d0", {24'd0, wr_data[base]}, 32'hBE);
    check("push_hl_a1", {16'd0, wr_addr[base+1]}, 32'h0000FFFF);
    check("push_hl_d1", {24'd0, wr_data[base+1]}, 32'hEF);
    check("push_hl_sp", {16'd0, sp_out}, 32'h0000FFFF);

    // PUSH DE = C3D4 with 3 wait cycles per byte; busy-time start and
    // sp_load must be ignored
    ack_delay = 3;
    rf_val[1] = 16'hC3D4;
    base = wr_cnt;
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    pair  = 2'b01;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n <= 8) begin
        check("dly_req", {31'd0, bus.mem_req}, 32'd1);
        check("dly_we", {31'd0, bus.mem_we}, 32'd1);
        check("dly_addr", {16'd0, bus.mem_addr}, (n <= 4) ? 32'h0000FFFE : 32'h0000FFFD);
        check("dly_wdata", {24'd0, bus.mem_wdata}, (n <= 4) ? 32'hC3 : 32'hD4);
        check("dly_done_low", {31'd0, done}, 32'd0);
      end else begin
        check("dly_done_9", {31'd0, done}, 32'd1);
      end
      if (n == 2) begin
        start = 1'b1;
        op = 1'b1;
        sp_load = 1'b1;
        sp_load_val = 16'h1234;
      end
      if (n == 3) begin
        start = 1'b0;
        sp_load = 1'b0;
      end
    end
    @(negedge clk);
    check("dly_sp", {16'd0, sp_out}, 32'h0000FFFD);
    check("dly_wr_cnt", wr_cnt - base, 2);
    check("dly_ready", {31'd0, ready}, 32'd1);
    ack_delay = 0;

    // Reset during POP_H abandons the pop
    wb0 = wb_cnt;
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    pair  = 2'b00;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_req_before", {31'd0, bus.mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mid_sp", {16'd0, sp_out}, 32'h0000FFFE);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_mid_no_wb", wb_cnt - wb0, 0);
    check("rst_mid_sp_after", {16'd0, sp_out}, 32'h0000FFFE);
    check("rst_mid_ready", {31'd0, ready}, 32'd1);

    // start together with sp_load in IDLE: load wins, start dropped
    base = wr_cnt;
    @(negedge clk);
    start = 1'b1;
    op = 1'b0;
    pair = 2'b00;
    sp_load = 1'b1;
    sp_load_val = 16'h8000;
    @(posedge clk);
    #1;
    start = 1'b0;
    sp_load = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("sim_no_req", {31'd0, bus.mem_req}, 32'd0);
    end
    check("sim_sp", {16'd0, sp_out}, 32'h00008000);
    check("sim_no_wr", wr_cnt - base, 0);
    check("sim_ready", {31'd0, ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
